// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between a controller and seq_alu_unit
interface seq_alu_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             zero;
  logic             flag;
  modport master (output start, op, a, b, input result, busy, done, zero, flag);
  modport slave  (input start, op, a, b, output result, busy, done, zero, flag);
endinterface

// File: rtl/seq_alu_unit.sv
// seq_alu_unit: sequential ALU with single-cycle arithmetic and iterative mul/div
module seq_alu_unit #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  typedef enum logic {IDLE, ITER} state_t;
  state_t state, state_n;
  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   ra, rb, nres;
  logic [2*WIDTH-1:0] p, pn;
  logic [WIDTH:0]     sum, dif, msum, dt, dd;
  logic               rmul, wr, load, nflag;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // p holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    state_n = state;
    wr = 1'b0;
    load = 1'b0;
    nres = '0;
    nflag = 1'b0;
    sum = {1'b0, bus.a} + {1'b0, bus.b};
    dif = {1'b0, bus.a} - {1'b0, bus.b};
    msum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, ra} : '0);
    dt = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    dd = dt - {1'b0, rb};
    pn = rmul ? {msum, p[WIDTH-1:1]}
       : dd[WIDTH] ? {dt[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
       : {dd[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    if (state == ITER) begin
      if (cnt == CNTW'(1)) begin
        wr = 1'b1;
        nres = pn[WIDTH-1:0];
        nflag = rmul && (|pn[2*WIDTH-1:WIDTH]);
        state_n = IDLE;
      end
    end else if (bus.start) begin
      wr = 1'b1;
      case (bus.op)
        3'b000: nres = bus.b;
        3'b001: {nflag, nres} = sum;
        3'b010: {nflag, nres} = dif;
        3'b011: nres = sum[WIDTH:1];
        3'b100: nres = bus.a >> bus.b[2:0];
        3'b101: begin
          wr = 1'b0;
          load = 1'b1;
          state_n = ITER;
        end
        3'b110: begin
          wr = (bus.b == '0);
          load = !wr;
          nres = '1;
          nflag = wr;
          state_n = wr ? IDLE : ITER;
        end
        default: nres = '0;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result <= '0;
      bus.done <= 1'b0;
      bus.zero <= 1'b0;
      bus.flag <= 1'b0;
      cnt <= '0;
      p <= '0;
      ra <= '0;
      rb <= '0;
      rmul <= 1'b0;
    end else begin
      bus.done <= wr;
      if (wr) begin
        bus.result <= nres;
        bus.flag <= nflag;
        bus.zero <= (nres == '0);
      end
      if (load) begin
        ra <= bus.a;
        rb <= bus.b;
        rmul <= (bus.op == 3'b101);
        cnt <= CNTW'(WIDTH);
        p <= {{WIDTH{1'b0}}, (bus.op == 3'b101) ? bus.b : bus.a};
      end else if (state == ITER) begin
        p <= pn;
        cnt <= cnt - CNTW'(1);
      end
    end
  end
  assign bus.busy = (state == ITER);
endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: vector table plus scoreboard checks of seq_alu_unit
module tb_seq_alu_unit;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  seq_alu_if #(W) sif ();
  seq_alu_unit #(.WIDTH(W), .CNTW(4)) dut (.clk(clk), .rst(rst), .bus(sif));

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         flg;
  } vec_t;
  typedef struct {
    logic [W-1:0] res;
    logic         flg;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tv[16];
  vec_t bb[4];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    sif.start = 1'b1;
    sif.op = v.op;
    sif.a = v.a;
    sif.b = v.b;
    e.res = v.res;
    e.flg = v.flg;
    e.cyc = (v.op == 3'b101 || (v.op == 3'b110 && v.b != 0)) ? W : 0;
    sb.push_back(e);
  endtask

  task automatic run(input vec_t v, input int idx);
    exp_t e;
    int n, bz;
    @(negedge clk);
    drive(v);
    @(negedge clk);
    sif.start = 1'b0;
    n = 0;
    bz = 0;
    while (!sif.done && n < 20) begin
      bz += int'(sif.busy);
      sif.a = W'($urandom);
      sif.b = W'($urandom);
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk($sformatf("done[%0d]", idx), 32'(sif.done), 1);
    chk($sformatf("result[%0d]", idx), 32'(sif.result), 32'(e.res));
    chk($sformatf("flag[%0d]", idx), 32'(sif.flag), 32'(e.flg));
    chk($sformatf("zero[%0d]", idx), 32'(sif.zero), 32'(e.res == 0));
    chk($sformatf("busycyc[%0d]", idx), 32'(bz), 32'(e.cyc));
    @(negedge clk);
    chk($sformatf("donepulse[%0d]", idx), 32'(sif.done), 0);
  endtask

  initial begin
    exp_t e;
    int n, dn;
    tv[0]  = '{3'b001, 8'hF0, 8'h20, 8'h10, 1'b1};
    tv[1]  = '{3'b011, 8'hFF, 8'hFD, 8'hFE, 1'b0};
    tv[2]  = '{3'b010, 8'h03, 8'h05, 8'hFE, 1'b1};
    tv[3]  = '{3'b010, 8'h05, 8'h05, 8'h00, 1'b0};
    tv[4]  = '{3'b000, 8'h33, 8'h5A, 8'h5A, 1'b0};
    tv[5]  = '{3'b100, 8'h80, 8'h03, 8'h10, 1'b0};
    tv[6]  = '{3'b100, 8'hF0, 8'h0B, 8'h1E, 1'b0};
    tv[7]  = '{3'b111, 8'h12, 8'h34, 8'h00, 1'b0};
    tv[8]  = '{3'b001, 8'hFF, 8'h01, 8'h00, 1'b1};
    tv[9]  = '{3'b101, 8'd20, 8'd13, 8'h04, 1'b1};
    tv[10] = '{3'b101, 8'd7,  8'd9,  8'h3F, 1'b0};
    tv[11] = '{3'b101, 8'hFF, 8'hFF, 8'h01, 1'b1};
    tv[12] = '{3'b110, 8'd200, 8'd7, 8'd28, 1'b0};
    tv[13] = '{3'b110, 8'd5,  8'd9,  8'h00, 1'b0};
    tv[14] = '{3'b110, 8'd5,  8'd0,  8'hFF, 1'b1};
    tv[15] = '{3'b110, 8'hFF, 8'h01, 8'hFF, 1'b0};
    bb[0]  = '{3'b001, 8'h01, 8'h02, 8'h03, 1'b0};
    bb[1]  = '{3'b010, 8'h01, 8'h02, 8'hFF, 1'b1};
    bb[2]  = '{3'b000, 8'h77, 8'h00, 8'h00, 1'b0};
    bb[3]  = '{3'b001, 8'h80, 8'h80, 8'h00, 1'b1};
    rst = 1'b1;
    sif.start = 1'b0;
    sif.op = '0;
    sif.a = '0;
    sif.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(sif.result), 0);
    chk("rst_busy", 32'(sif.busy), 0);
    chk("rst_done", 32'(sif.done), 0);
    chk("rst_zero", 32'(sif.zero), 0);
    chk("rst_flag", 32'(sif.flag), 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) run(tv[i], i);

    // start held high: one accepted op per edge
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        chk($sformatf("b2b_done[%0d]", i), 32'(sif.done), 1);
        chk($sformatf("b2b_result[%0d]", i), 32'(sif.result), 32'(e.res));
        chk($sformatf("b2b_flag[%0d]", i), 32'(sif.flag), 32'(e.flg));
      end
      if (i < 4) drive(bb[i]);
      else sif.start = 1'b0;
    end

    // start stays high through the whole MUL; only the edge after done accepts ADD
    @(negedge clk);
    drive('{3'b101, 8'd7, 8'd9, 8'h3F, 1'b0});
    @(negedge clk);
    sif.op = 3'b001;
    sif.a = 8'h01;
    sif.b = 8'h01;
    n = 0;
    dn = 0;
    while (!sif.done && n < 20) begin
      dn += int'(sif.busy);
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk("hold_done", 32'(sif.done), 1);
    chk("hold_result", 32'(sif.result), 32'(e.res));
    chk("hold_busycyc", 32'(dn), W);
    @(negedge clk);
    sif.start = 1'b0;
    chk("hold_add_done", 32'(sif.done), 1);
    chk("hold_add_result", 32'(sif.result), 8'h02);
    chk("hold_add_flag", 32'(sif.flag), 0);

    // start pulsed mid-ITER is dropped
    @(negedge clk);
    drive('{3'b101, 8'd20, 8'd13, 8'h04, 1'b1});
    @(negedge clk);
    sif.start = 1'b0;
    repeat (2) @(negedge clk);
    sif.start = 1'b1;
    sif.op = 3'b001;
    sif.a = 8'h01;
    sif.b = 8'h01;
    @(negedge clk);
    sif.start = 1'b0;
    e = sb.pop_front();
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      if (sif.done) begin
        dn++;
        chk("ign_result", 32'(sif.result), 32'(e.res));
        chk("ign_flag", 32'(sif.flag), 32'(e.flg));
      end
      @(negedge clk);
    end
    chk("ign_done_count", 32'(dn), 1);

    // reset mid-ITER aborts without a done pulse
    @(negedge clk);
    sif.start = 1'b1;
    sif.op = 3'b101;
    sif.a = 8'd7;
    sif.b = 8'd9;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", 32'(sif.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_result", 32'(sif.result), 0);
    chk("abort_busy", 32'(sif.busy), 0);
    chk("abort_done", 32'(sif.done), 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dn += int'(sif.done) + int'(sif.busy);
    end
    chk("abort_quiet", 32'(dn), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
